// File: rtl/serial_fsm_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
//   Shared types and helpers for serial_fsm_sequencer.
//   - seq_state_t : frame controller states.
//   - clog2_w     : ceil(log2(n)) with a floor of 1, used to size the bit
//                   index and the ones counter.
// ---------------------------------------------------------------------------
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // Number of bits needed to hold the values 0..n-1. Never returns 0,
  // so a counter built from it always has at least one bit.
  function automatic int clog2_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/serial_fsm_sequencer.sv
// ---------------------------------------------------------------------------
// serial_fsm_sequencer
//   Frame-level controller for a bit-serial sequence detector. Takes a
//   WIDTH-bit word over valid/ready, optionally pulses a detector clear,
//   feeds the word one bit per cycle on fsm_x, captures the detector output
//   fsm_y for each bit into out_data and counts the ones in out_ones.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   producer offers a frame
//   in_ready   frame accepted this cycle when in_valid is also high
//   in_data    frame bits
//   in_clear   clear the detector before feeding (qualified by accept)
//   abort      discard the frame in flight (CLEAR/SHIFT only)
//   fsm_clr    synchronous clear pulse to the detector
//   fsm_en     detector advances at this clock edge
//   fsm_x      serial bit to the detector
//   fsm_y      detector output (combinational from its state and x)
//   out_valid  result available
//   out_ready  consumer takes the result
//   out_data   bit i = y sampled while in_data bit i was applied
//   out_ones   popcount of out_data
//   busy       state is CLEAR or SHIFT
// ---------------------------------------------------------------------------
module serial_fsm_sequencer
  import seq_pkg::*;
#(
  parameter int       WIDTH     = 8,
  parameter bit       LSB_FIRST = 1'b1,
  localparam int      OW        = clog2_w(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_clear,
  input  logic             abort,
  output logic             fsm_clr,
  output logic             fsm_en,
  output logic             fsm_x,
  input  logic             fsm_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OW-1:0]    out_ones,
  output logic             busy
);

  localparam int IW = clog2_w(WIDTH);

  seq_state_t       state_q, state_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] res_q;
  logic [IW-1:0]    idx_q;
  logic [OW-1:0]    ones_q;
  logic             pend_q;   // a frame is waiting behind the CLEAR cycle

  logic             accept;
  logic             last_bit;
  logic [IW-1:0]    pos;      // bit position fed / captured this cycle

  // Ready depends only on state and the consumer, never on in_valid, so a
  // DONE result can be handed off and a new frame taken in the same cycle.
  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign last_bit = (idx_q == IW'(WIDTH - 1));
  assign pos      = LSB_FIRST ? idx_q : (IW'(WIDTH - 1) - idx_q);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: state_d is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = in_clear ? CLEAR : SHIFT;
      // An abort here re-enters CLEAR with pend_q dropped, so the detector
      // is cleared once more and the controller then falls back to IDLE.
      CLEAR: if (abort)       state_d = CLEAR;
             else if (pend_q) state_d = SHIFT;
             else             state_d = IDLE;
      // Abort is checked first so it wins even on the last bit.
      SHIFT: if (abort)         state_d = CLEAR;
             else if (last_bit) state_d = DONE;
      DONE:  if (accept)         state_d = in_clear ? CLEAR : SHIFT;
             else if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic (Moore, decoded from the registered state)
  // -------------------------------------------------------------------------
  always_comb begin
    fsm_clr   = 1'b0;
    fsm_en    = 1'b0;
    fsm_x     = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      CLEAR: begin
        fsm_clr = 1'b1;
        busy    = 1'b1;
      end
      SHIFT: begin
        fsm_en  = 1'b1;
        fsm_x   = data_q[pos];
        busy    = 1'b1;
      end
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Frame datapath: latched word, bit index, captured result, ones count
  // -------------------------------------------------------------------------
  // NOTE: the data registers are reset along with the control state because
  // out_data and out_ones are visible outputs that must read 0 in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
      res_q  <= '0;
      idx_q  <= '0;
      ones_q <= '0;
      pend_q <= 1'b0;
    end else if (accept) begin
      data_q <= in_data;
      res_q  <= '0;
      idx_q  <= '0;
      ones_q <= '0;
      pend_q <= 1'b1;
    end else if (busy && abort) begin
      // Partial result is thrown away; nothing of it ever reaches out_valid.
      res_q  <= '0;
      idx_q  <= '0;
      ones_q <= '0;
      pend_q <= 1'b0;
    end else if (state_q == SHIFT) begin
      res_q[pos] <= fsm_y;
      ones_q     <= ones_q + OW'(fsm_y);
      idx_q      <= idx_q + 1'b1;
    end
  end

  assign out_data = res_q;
  assign out_ones = ones_q;

endmodule

// File: tb/tb_serial_fsm_sequencer.sv
// ---------------------------------------------------------------------------
// tb_serial_fsm_sequencer
//   Two sequencers (LSB-first and MSB-first, WIDTH=8) share every input and
//   each drives its own behavioural detector. Expected results come from a
//   frame-level model: walk the word in feed order and apply the detector
//   rule selected by `mode`:
//     0: y = x      1: y = ~x      2: y = x & previous fed x (cleared by clr)
// ---------------------------------------------------------------------------
module tb_serial_fsm_sequencer;

  localparam int W  = 8;
  localparam int OW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_clear, abort, out_ready;
  logic [W-1:0]  in_data;

  logic          in_ready_w  [2];
  logic          fsm_clr_w   [2];
  logic          fsm_en_w    [2];
  logic          fsm_x_w     [2];
  logic          fsm_y_w     [2];
  logic          out_valid_w [2];
  logic          busy_w      [2];
  logic [W-1:0]  out_data_w  [2];
  logic [OW-1:0] out_ones_w  [2];

  int            mode;
  int            total = 0;
  int            bad   = 0;

  // Model state: expected result of the frame in flight, and the detector's
  // remembered bit as the model sees it between frames.
  logic [W-1:0]  exp_res [2];
  logic          prev_m  [2];

  always #5 clk = ~clk;

  serial_fsm_sequencer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready_w[0]), .in_data(in_data),
    .in_clear(in_clear), .abort(abort),
    .fsm_clr(fsm_clr_w[0]), .fsm_en(fsm_en_w[0]), .fsm_x(fsm_x_w[0]),
    .fsm_y(fsm_y_w[0]),
    .out_valid(out_valid_w[0]), .out_ready(out_ready),
    .out_data(out_data_w[0]), .out_ones(out_ones_w[0]), .busy(busy_w[0])
  );

  serial_fsm_sequencer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready_w[1]), .in_data(in_data),
    .in_clear(in_clear), .abort(abort),
    .fsm_clr(fsm_clr_w[1]), .fsm_en(fsm_en_w[1]), .fsm_x(fsm_x_w[1]),
    .fsm_y(fsm_y_w[1]),
    .out_valid(out_valid_w[1]), .out_ready(out_ready),
    .out_data(out_data_w[1]), .out_ones(out_ones_w[1]), .busy(busy_w[1])
  );

  for (genvar g = 0; g < 2; g++) begin : g_det
    logic det_q;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)             det_q <= 1'b0;
      else if (fsm_clr_w[g])  det_q <= 1'b0;
      else if (fsm_en_w[g])   det_q <= fsm_x_w[g];
    end
    assign fsm_y_w[g] = (mode == 0) ? fsm_x_w[g] :
                        (mode == 1) ? ~fsm_x_w[g] : (fsm_x_w[g] & det_q);
  end

  // Frame-level reference: walk bits in feed order applying the mode rule.
  function automatic logic [W-1:0] model_res(input logic [W-1:0] d,
                                             input bit lsb, input int m,
                                             input logic start);
    logic [W-1:0] r;
    logic         p, x;
    int           b;
    r = '0;
    p = start;
    for (int k = 0; k < W; k++) begin
      b    = lsb ? k : W - 1 - k;
      x    = d[b];
      r[b] = (m == 0) ? x : (m == 1) ? ~x : (x & p);
      p    = x;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a frame and return one step after the accepting edge.
  task automatic accept_frame(input logic [W-1:0] d, input logic clr,
                              output int waited);
    in_valid = 1'b1;
    in_data  = d;
    in_clear = clr;
    #1;
    waited = 0;
    while (!in_ready_w[0] && waited < 40) begin
      tick();
      waited++;
    end
    total++;
    if (in_ready_w[0] !== 1'b1) begin
      bad++;
      $display("FAIL accept_wait: in_ready got %b want 1", in_ready_w[0]);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_clear = 1'b0;
    in_data  = W'($urandom);
    for (int g = 0; g < 2; g++) begin
      exp_res[g] = model_res(d, g == 0, mode, clr ? 1'b0 : prev_m[g]);
      prev_m[g]  = (g == 0) ? d[W-1] : d[0];
    end
  endtask

  // Follow a frame from one step after acceptance until out_valid, checking
  // the fed bit stream, clear pulses, latency and the final result.
  task automatic collect(input logic [W-1:0] d, input logic clr);
    int           cnt;
    int           clrs [2];
    int           nx   [2];
    logic [W-1:0] xs   [2];
    logic [W-1:0] want_x;
    cnt = 1;  // the accepting edge counts as cycle 1
    for (int g = 0; g < 2; g++) begin
      clrs[g] = 0;
      nx[g]   = 0;
      xs[g]   = '0;
    end
    while (!out_valid_w[0] && cnt < 3 * W) begin
      for (int g = 0; g < 2; g++) begin
        if (fsm_clr_w[g] === 1'b1) begin
          clrs[g]++;
          total++;
          if (fsm_en_w[g] !== 1'b0) begin
            bad++;
            $display("FAIL clr_en dut%0d: fsm_en got %b want 0", g, fsm_en_w[g]);
          end
        end
        if (fsm_en_w[g] === 1'b1) begin
          if (nx[g] < W) xs[g][nx[g]] = fsm_x_w[g];
          nx[g]++;
        end else begin
          total++;
          if (fsm_x_w[g] !== 1'b0) begin
            bad++;
            $display("FAIL x_idle dut%0d: fsm_x got %b want 0", g, fsm_x_w[g]);
          end
        end
      end
      tick();
      cnt++;
    end
    total++;
    if (cnt !== W + 1 + (clr ? 1 : 0)) begin
      bad++;
      $display("FAIL latency: got %0d want %0d", cnt, W + 1 + (clr ? 1 : 0));
    end
    for (int g = 0; g < 2; g++) begin
      for (int k = 0; k < W; k++) want_x[k] = (g == 0) ? d[k] : d[W-1-k];
      total++;
      if (out_valid_w[g] !== 1'b1) begin
        bad++;
        $display("FAIL out_valid dut%0d: got %b want 1", g, out_valid_w[g]);
      end
      total++;
      if (nx[g] !== W || xs[g] !== want_x) begin
        bad++;
        $display("FAIL x_seq dut%0d: got %0d bits %h want %0d bits %h",
                 g, nx[g], xs[g], W, want_x);
      end
      total++;
      if (clrs[g] !== (clr ? 1 : 0)) begin
        bad++;
        $display("FAIL clr_count dut%0d: got %0d want %0d", g, clrs[g], clr ? 1 : 0);
      end
      total++;
      if (out_data_w[g] !== exp_res[g]) begin
        bad++;
        $display("FAIL out_data dut%0d: got %h want %h", g, out_data_w[g], exp_res[g]);
      end
      total++;
      if (out_ones_w[g] !== OW'($countones(exp_res[g]))) begin
        bad++;
        $display("FAIL out_ones dut%0d: got %0d want %0d",
                 g, out_ones_w[g], $countones(exp_res[g]));
      end
    end
  endtask

  // Full frame with out_ready already high: result is taken one cycle later.
  task automatic do_frame(input logic [W-1:0] d, input logic clr);
    int w;
    accept_frame(d, clr, w);
    collect(d, clr);
    tick();
    for (int g = 0; g < 2; g++) begin
      total++;
      if ({out_valid_w[g], in_ready_w[g]} !== 2'b01) begin
        bad++;
        $display("FAIL post_handshake dut%0d: valid/ready got %b want 01",
                 g, {out_valid_w[g], in_ready_w[g]});
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; in_clear = 1'b0; abort = 1'b0;
    out_ready = 1'b1; in_data = '0; mode = 0;
    prev_m[0] = 1'b0; prev_m[1] = 1'b0;
    #3;
    for (int g = 0; g < 2; g++) begin
      total++;
      if ({in_ready_w[g], fsm_clr_w[g], fsm_en_w[g], fsm_x_w[g], out_valid_w[g],
           busy_w[g], out_ones_w[g], out_data_w[g]} !==
          {1'b1, 5'b0, {OW{1'b0}}, {W{1'b0}}}) begin
        bad++;
        $display("FAIL reset_values dut%0d: got %h", g,
                 {in_ready_w[g], fsm_clr_w[g], fsm_en_w[g], fsm_x_w[g],
                  out_valid_w[g], busy_w[g], out_ones_w[g], out_data_w[g]});
      end
    end
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();       // y = x, A5 -> A5 / 4 ones, latency 9
    mode = 0;
    do_frame(8'hA5, 1'b0);
  endtask

  task automatic test_clear();       // y = ~x with clear -> 5A, latency 10
    mode = 1;
    do_frame(8'hA5, 1'b1);
  endtask

  task automatic test_single_bit();  // 80: MSB-first feeds the 1 first
    mode = 0;
    do_frame(8'h80, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d1;
    int           w;
    mode      = 0;
    out_ready = 1'b0;
    d1        = W'($urandom);
    accept_frame(d1, 1'b0, w);
    collect(d1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      tick();
      for (int g = 0; g < 2; g++) begin
        total++;
        if ({out_valid_w[g], in_ready_w[g], out_data_w[g]} !==
            {1'b1, 1'b0, exp_res[g]}) begin
          bad++;
          $display("FAIL done_hold dut%0d: got %b/%b/%h want 1/0/%h", g,
                   out_valid_w[g], in_ready_w[g], out_data_w[g], exp_res[g]);
        end
      end
    end
    out_ready = 1'b1;
    accept_frame(8'hFF, 1'b0, w);
    total++;
    if (w !== 0) begin
      bad++;
      $display("FAIL done_accept_wait: got %0d cycles want 0", w);
    end
    for (int g = 0; g < 2; g++) begin
      total++;
      if ({fsm_en_w[g], out_valid_w[g]} !== 2'b10) begin
        bad++;
        $display("FAIL no_bubble dut%0d: en/valid got %b want 10",
                 g, {fsm_en_w[g], out_valid_w[g]});
      end
    end
    collect(8'hFF, 1'b0);
    tick();
  endtask

  task automatic test_abort();
    int w;
    // Abort on the 4th SHIFT cycle, stateful detector so the clear matters.
    mode = 2;
    accept_frame(W'($urandom), 1'b0, w);
    for (int c = 0; c < 3; c++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int g = 0; g < 2; g++) begin
      total++;
      if ({fsm_clr_w[g], fsm_en_w[g], out_valid_w[g]} !== 3'b100) begin
        bad++;
        $display("FAIL abort_clear dut%0d: clr/en/valid got %b want 100",
                 g, {fsm_clr_w[g], fsm_en_w[g], out_valid_w[g]});
      end
      prev_m[g] = 1'b0;
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      for (int g = 0; g < 2; g++) begin
        total++;
        if ({fsm_clr_w[g], busy_w[g], out_valid_w[g], in_ready_w[g]} !== 4'b0001) begin
          bad++;
          $display("FAIL abort_idle dut%0d: clr/busy/valid/ready got %b want 0001",
                   g, {fsm_clr_w[g], busy_w[g], out_valid_w[g], in_ready_w[g]});
        end
      end
    end
    do_frame(W'($urandom), 1'b0);
    mode = 0;
    do_frame(8'h0F, 1'b0);

    // Abort on the last SHIFT cycle: abort wins, no result.
    accept_frame(W'($urandom), 1'b0, w);
    for (int c = 0; c < W - 1; c++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int g = 0; g < 2; g++) begin
      total++;
      if ({fsm_clr_w[g], out_valid_w[g]} !== 2'b10) begin
        bad++;
        $display("FAIL abort_last dut%0d: clr/valid got %b want 10",
                 g, {fsm_clr_w[g], out_valid_w[g]});
      end
      prev_m[g] = 1'b0;
    end
    tick();

    // Abort while idle is ignored.
    abort = 1'b1;
    tick();
    tick();
    for (int g = 0; g < 2; g++) begin
      total++;
      if ({fsm_clr_w[g], busy_w[g], in_ready_w[g]} !== 3'b001) begin
        bad++;
        $display("FAIL abort_in_idle dut%0d: clr/busy/ready got %b want 001",
                 g, {fsm_clr_w[g], busy_w[g], in_ready_w[g]});
      end
    end
    abort = 1'b0;
  endtask

  task automatic test_reset_mid();
    int w;
    mode = 2;
    accept_frame(W'($urandom), 1'b0, w);
    tick();
    tick();          // now in SHIFT cycle 3
    reset = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      total++;
      if ({in_ready_w[g], fsm_clr_w[g], fsm_en_w[g], fsm_x_w[g], out_valid_w[g],
           busy_w[g], out_ones_w[g], out_data_w[g]} !==
          {1'b1, 5'b0, {OW{1'b0}}, {W{1'b0}}}) begin
        bad++;
        $display("FAIL reset_mid dut%0d: got %h", g,
                 {in_ready_w[g], fsm_clr_w[g], fsm_en_w[g], fsm_x_w[g],
                  out_valid_w[g], busy_w[g], out_ones_w[g], out_data_w[g]});
      end
      prev_m[g] = 1'b0;
    end
    tick();
    reset = 1'b1;
    tick();
    do_frame(W'($urandom), 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      mode = int'($urandom_range(0, 2));
      do_frame(W'($urandom), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clear();
    test_single_bit();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_fsm_sequencer.md
Name: serial_fsm_sequencer

Overview:
Frame-level controller for the team's bit-serial sequence-detector FSMs (single input x, single output y). It accepts a parallel WIDTH-bit word over a valid/ready handshake and can optionally clear the detector first. It then feeds the word to the detector one bit per cycle, captures the detector's y for each bit into a result word, and counts result ones. It sits between a parallel producer/consumer and one detector instance.

Parameters:
WIDTH, 8, bits per frame; legal range 2..32.
LSB_FIRST, 1, 1 = bit 0 is fed first; 0 = bit WIDTH-1 is fed first.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset.
in_valid  input  1  producer offers a frame.
in_ready  output  1  sequencer accepts a frame this cycle.
in_data  input  WIDTH  frame bits.
in_clear  input  1  qualified by the input handshake; clear the detector before feeding.
abort  input  1  discard the frame in flight.
fsm_clr  output  1  synchronous clear pulse to the detector.
fsm_en  output  1  detector advances at this clock edge.
fsm_x  output  1  serial bit to the detector.
fsm_y  input  1  detector output; combinational from the current detector state and x.
out_valid  output  1  result available.
out_ready  input  1  consumer takes the result.
out_data  output  WIDTH  captured y bits; bit i is y sampled while in_data bit i was applied.
out_ones  output  $clog2(WIDTH+1)  popcount of out_data.
busy  output  1  state is CLEAR or SHIFT.

Behaviour:
- State machine states: IDLE, CLEAR, SHIFT, DONE (seq_state_t). All state is held in flops with asynchronous active-low reset.
- Values while reset is asserted: state=IDLE, fsm_clr=0, fsm_en=0, fsm_x=0, out_valid=0, out_data=0, out_ones=0, busy=0, in_ready=1.
- in_ready = (state==IDLE) | (state==DONE & out_ready). It is combinational and independent of in_valid.
- Accept: in_valid & in_ready at a clock edge. At that edge:
  - in_data is latched into data_q.
  - The bit index is set to 0, and the result and ones registers are cleared.
  - Next state is CLEAR if in_clear=1, otherwise SHIFT.
- CLEAR (exactly 1 cycle): fsm_clr=1, fsm_en=0. Next state is SHIFT if a frame is pending, otherwise IDLE (the abort path).
- SHIFT (exactly WIDTH cycles):
  - fsm_en=1.
  - fsm_x = data_q[idx] when LSB_FIRST=1, otherwise data_q[WIDTH-1-idx].
  - At each edge, fsm_y is written to result bit position idx (or WIDTH-1-idx), out_ones increments when fsm_y=1, and idx increments.
  - At idx==WIDTH-1 the next state is DONE.
- DONE: out_valid=1. out_data and out_ones are held stable until out_valid & out_ready.
  - Handshake with no new accept in the same cycle: next state IDLE.
  - Simultaneous handshake and accept: the new frame starts with no bubble.
- fsm_x=0 in every state other than SHIFT.
- Latency: from the accept edge to first out_valid is WIDTH+1 cycles, or WIDTH+2 with in_clear.
- Throughput: back-to-back frames arrive every WIDTH+1 cycles while out_ready is held at 1.
- abort:
  - Ignored in IDLE and DONE.
  - In SHIFT or CLEAR, the next state is CLEAR with the pending flag cleared, so exactly one fsm_clr pulse follows and then the state returns to IDLE.
  - The partial result is discarded and out_valid is never raised for that frame.
  - If abort arrives on the last SHIFT cycle, abort wins.
- Reset asserted mid-frame: the frame is dropped and all outputs take their reset values immediately. The detector is reset by its own reset; no fsm_clr pulse is issued.
- in_clear is ignored unless in_valid & in_ready.
- out_ones width holds WIDTH exactly; no wrap is possible.

Decomposition:
- Package seq_pkg: typedef enum logic [1:0] seq_state_t {IDLE, CLEAR, SHIFT, DONE}; function clog2_w for the counter widths.
- The index counter and the result shift/capture logic are inline. No sub-module is warranted.
- The bench instantiates a reference detector, or a behavioural y model, on the fsm_* ports.

Test Plan:
1. WIDTH=8, LSB_FIRST=1, bench model y=x, in_data=8'hA5, in_clear=0 -> fsm_x sequence 1,0,1,0,0,1,0,1; out_valid 9 cycles after accept; out_data=8'hA5; out_ones=4.
2. Same stimulus with in_clear=1 and y=~x -> exactly one fsm_clr pulse with fsm_en=0 in that cycle; out_valid after 10 cycles; out_data=8'h5A; out_ones=4.
3. LSB_FIRST=0, in_data=8'h80, y=x -> fsm_x=1 on the first SHIFT cycle only; out_data=8'h80; out_ones=1.
4. out_ready held 0 for 5 cycles in DONE -> out_valid stays 1, out_data is stable, in_ready=0. Then out_ready=1 together with in_valid=1 and in_data=8'hFF -> the next frame's first SHIFT is the following cycle; the second result is out_data=8'hFF, out_ones=8.
5. abort asserted on the 4th SHIFT cycle -> one CLEAR cycle with fsm_clr=1, then IDLE; no out_valid; a following frame 8'h0F returns out_data=8'h0F.
6. reset driven low during SHIFT cycle 3 -> all outputs are at their reset values in the same cycle; after release, in_ready=1 and a new frame completes normally.
